// File: rtl/io_dmem_responder_if.sv
// Accelerator-side channels of the DMem responder: read request, read data,
// write request, write data and write status.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1; the payload is sampled on that edge.
// A source holds valid and payload stable until the transfer completes.
interface io_dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0] req_read_addr;
    logic              req_read_addr_valid;
    logic              req_read_addr_ready;
    logic [31:0]       req_read_len;
    logic [DWIDTH-1:0] resp_read_data;
    logic              resp_read_data_valid;
    logic              resp_read_data_ready;
    logic [AWIDTH-1:0] req_write_addr;
    logic              req_write_addr_valid;
    logic              req_write_addr_ready;
    logic [31:0]       req_write_len;
    logic [DWIDTH-1:0] req_write_data;
    logic              req_write_data_valid;
    logic              req_write_data_ready;
    logic              resp_write_status;
    logic              resp_write_status_valid;
    logic              resp_write_status_ready;

    // Responder side (the DMem server)
    modport slave (
        input  req_read_addr, req_read_addr_valid, req_read_len,
        output req_read_addr_ready,
        output resp_read_data, resp_read_data_valid,
        input  resp_read_data_ready,
        input  req_write_addr, req_write_addr_valid, req_write_len,
        output req_write_addr_ready,
        input  req_write_data, req_write_data_valid,
        output req_write_data_ready,
        output resp_write_status, resp_write_status_valid,
        input  resp_write_status_ready
    );

    // Requester side (the accelerator)
    modport master (
        output req_read_addr, req_read_addr_valid, req_read_len,
        input  req_read_addr_ready,
        input  resp_read_data, resp_read_data_valid,
        output resp_read_data_ready,
        output req_write_addr, req_write_addr_valid, req_write_len,
        input  req_write_addr_ready,
        output req_write_data, req_write_data_valid,
        input  req_write_data_ready,
        input  resp_write_status, resp_write_status_valid,
        output resp_write_status_ready
    );
endinterface

// File: rtl/io_dmem_responder.sv
// Serves accelerator read/write bursts against a single-port, synchronous-read
// DMem, one burst at a time. Read data passes through a 2-entry FIFO so the
// one-cycle DMem latency never loses a beat under backpressure.
module io_dmem_responder #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MEM_AWIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active low
    io_dmem_responder_if.slave    bus,
    output logic [MEM_AWIDTH-1:0] dmem_addr,
    output logic                  dmem_en,
    output logic [DWIDTH/8-1:0]   dmem_we,
    output logic [DWIDTH-1:0]     dmem_din,
    input  logic [DWIDTH-1:0]     dmem_dout,
    output logic                  idle,
    output logic [1:0]            state_dbg
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD    = 2'd1;
    localparam logic [1:0] S_WR    = 2'd2;
    localparam logic [1:0] S_WRESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       cnt_q, cnt_d;      // beats issued (read) or accepted (write)
    logic              rdy_en_q;          // keeps request readies low while in reset
    logic              inflight_q;        // a DMem read was issued last cycle
    logic [DWIDTH-1:0] fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic       aw_hs, ar_hs, w_hs, rd_pop, rd_issue;
    logic [2:0] rd_occ;

    // Request acceptance: write has fixed priority over read in IDLE
    assign bus.req_write_addr_ready = rdy_en_q && (state_q == S_IDLE);
    assign bus.req_read_addr_ready  = rdy_en_q && (state_q == S_IDLE) && !bus.req_write_addr_valid;
    assign aw_hs = bus.req_write_addr_valid && bus.req_write_addr_ready;
    assign ar_hs = bus.req_read_addr_valid && bus.req_read_addr_ready;

    // Read path: FIFO head drives the data channel
    assign bus.resp_read_data_valid = (count_q != 2'd0);
    assign bus.resp_read_data       = fifo_q[rd_ptr_q];
    assign rd_pop = bus.resp_read_data_valid && bus.resp_read_data_ready;

    // Occupancy after this cycle's pop plus the read already in flight; a new
    // read is issued only if its data is guaranteed a FIFO slot on return.
    assign rd_occ   = {1'b0, count_q} - {2'b00, rd_pop} + {2'b00, inflight_q};
    assign rd_issue = (state_q == S_RD) && (cnt_q != len_q) && (rd_occ < 3'd2);
    assign count_d  = count_q + {1'b0, inflight_q} - {1'b0, rd_pop};

    // Write path and status
    assign bus.req_write_data_ready    = (state_q == S_WR);
    assign w_hs = bus.req_write_data_valid && bus.req_write_data_ready;
    assign bus.resp_write_status_valid = (state_q == S_WRESP);
    assign bus.resp_write_status       = (state_q == S_WRESP);

    // DMem port: write beats pass straight through in the handshake cycle
    assign dmem_en   = rd_issue || w_hs;
    assign dmem_we   = w_hs ? {(DWIDTH/8){1'b1}} : {(DWIDTH/8){1'b0}};
    assign dmem_addr = dmem_en ? addr_q[MEM_AWIDTH-1:0] : {MEM_AWIDTH{1'b0}};
    assign dmem_din  = w_hs ? bus.req_write_data : {DWIDTH{1'b0}};

    assign idle      = (state_q == S_IDLE) && (count_q == 2'd0) && !inflight_q;
    assign state_dbg = state_q;

    // Next-state, burst address and beat counter
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs) begin
                    addr_d  = bus.req_write_addr;
                    len_d   = (bus.req_write_len == 32'd0) ? 32'd1 : bus.req_write_len;
                    cnt_d   = 32'd0;
                    state_d = S_WR;
                end else if (ar_hs) begin
                    addr_d  = bus.req_read_addr;
                    len_d   = (bus.req_read_len == 32'd0) ? 32'd1 : bus.req_read_len;
                    cnt_d   = 32'd0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (rd_issue) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                end
                // Leave as the last beat is handed over
                if ((cnt_q == len_q) && !inflight_q && (count_d == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (w_hs) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                    if (cnt_q + 32'd1 == len_q) begin
                        state_d = S_WRESP;
                    end
                end
            end
            default: begin
                if (bus.resp_write_status_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rdy_en_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rdy_en_q   <= 1'b1;
            inflight_q <= rd_issue;
        end
    end

    // Read-data FIFO: captures DMem output the cycle after each issued read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= dmem_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (rd_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_io_dmem_responder.sv
// Bench for io_dmem_responder: directed bursts from the test plan followed by
// random read/write bursts, checked against a word-array model of DMem.
module tb_io_dmem_responder;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAW   = 14;
    localparam int DEPTH = 1 << MAW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    io_dmem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    logic [MAW-1:0]  dmem_addr;
    logic            dmem_en;
    logic [DW/8-1:0] dmem_we;
    logic [DW-1:0]   dmem_din;
    logic [DW-1:0]   dmem_dout = '0;
    logic            idle;
    logic [1:0]      state_dbg;

    io_dmem_responder #(.AWIDTH(AW), .DWIDTH(DW), .MEM_AWIDTH(MAW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dmem_addr (dmem_addr),
        .dmem_en   (dmem_en),
        .dmem_we   (dmem_we),
        .dmem_din  (dmem_din),
        .dmem_dout (dmem_dout),
        .idle      (idle),
        .state_dbg (state_dbg)
    );

    // DMem environment (synchronous read) and the reference word array
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (dmem_en) begin
            if (dmem_we != '0) mem[dmem_addr] = dmem_din;
            else               dmem_dout <= mem[dmem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] addr, input int i);
        return int'((addr + 32'(i)) % 32'(DEPTH));
    endfunction

    // ---------------- read-ready driver ----------------
    int rr_mode = 0;          // 0: always 1, 1: random, 2: fixed toggle pattern
    int pat_idx = 0;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.resp_read_data_ready = 1'b1;
            1:       bus.resp_read_data_ready = 1'($urandom_range(0, 1));
            default: begin
                bus.resp_read_data_ready = pat[pat_idx];
                pat_idx = (pat_idx + 1) % 7;
            end
        endcase
    end

    // ---------------- read-channel monitor ----------------
    int            issued = 0, accepted = 0;
    bit            stall_prev = 0, rvalid_prev = 0, lat_arm = 0;
    int            ar_cyc = 0;
    logic [DW-1:0] stall_data, mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            issued = 0; accepted = 0; stall_prev = 0; rvalid_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("rd_hold_valid", bus.resp_read_data_valid, 1);
                chk("rd_hold_data", bus.resp_read_data, stall_data);
            end
            if (lat_arm && bus.resp_read_data_valid && !rvalid_prev) begin
                chk("rd_latency", cyc - ar_cyc, 2);
                lat_arm = 0;
            end
            if (bus.resp_read_data_valid && bus.resp_read_data_ready) begin
                chk("rd_beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("rd_data", bus.resp_read_data, mon_exp);
                end
                accepted++;
            end
            if (dmem_en && dmem_we == '0) begin
                issued++;
                chk("rd_outstanding_le2", (issued - accepted) <= 2, 1);
            end
            if (dmem_en && dmem_we != '0) chk("wr_we_all_ones", dmem_we, {(DW/8){1'b1}});
            stall_prev  = bus.resp_read_data_valid && !bus.resp_read_data_ready;
            stall_data  = bus.resp_read_data;
            rvalid_prev = bus.resp_read_data_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [31:0] addr, input logic [31:0] len,
                           input bit arm_lat, output int hs_cyc);
        int beats;
        bit ok;
        int t;
        beats  = (len == 0) ? 1 : int'(len);
        hs_cyc = 0;
        ok     = 0;
        @(posedge clk); #1;
        bus.req_read_addr = addr;
        bus.req_read_len  = len;
        bus.req_read_addr_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.req_read_addr_ready) begin ok = 1; break; end
        end
        if (!ok) chk("rd_req_ready", bus.req_read_addr_ready, 1);
        @(posedge clk); #1;
        bus.req_read_addr_valid = 1'b0;
        if (!ok) return;
        hs_cyc = cyc;
        for (int i = 0; i < beats; i++) exp_q.push_back(ref_mem[idx(addr, i)]);
        if (arm_lat) begin ar_cyc = cyc; lat_arm = 1; end
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rd_drain", exp_q.size(), 0);
        exp_q.delete();
        chk("idle_after_rd", idle, 1);
        chk("rvalid_after_rd", bus.resp_read_data_valid, 0);
    endtask

    task automatic wr_addr_hs(input logic [31:0] addr, input logic [31:0] len, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        bus.req_write_addr = addr;
        bus.req_write_len  = len;
        bus.req_write_addr_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.req_write_addr_ready) begin ok = 1; break; end
        end
        if (!ok) chk("wr_req_ready", bus.req_write_addr_ready, 1);
        @(posedge clk); #1;
        bus.req_write_addr_valid = 1'b0;
    endtask

    // Presents one beat (caller is at posedge+1) and returns at posedge+1
    // after the edge on which it was accepted.
    task automatic wr_beat(input logic [DW-1:0] data, output bit ok);
        ok = 0;
        bus.req_write_data = data;
        bus.req_write_data_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_write_data_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("wr_beat_ready", bus.req_write_data_ready, 1);
        else begin @(posedge clk); #1; end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] len, input bit fixed,
                            input int gap_at, input int hold, output int done_cyc);
        int beats;
        bit ok;
        logic [DW-1:0] d;
        beats    = (len == 0) ? 1 : int'(len);
        done_cyc = 0;
        wr_addr_hs(addr, len, ok);
        if (!ok) return;
        for (int i = 0; i < beats; i++) begin
            if (gap_at == i || (gap_at == -2 && $urandom_range(0, 3) == 0)) begin
                bus.req_write_data_valid = 1'b0;
                @(posedge clk); #1;
            end
            d = fixed ? DW'(i + 1) : DW'($urandom);
            wr_beat(d, ok);
            if (!ok) begin bus.req_write_data_valid = 1'b0; return; end
            ref_mem[idx(addr, i)] = d;
        end
        bus.req_write_data_valid = 1'b0;
        chk("wr_status_valid", bus.resp_write_status_valid, 1);
        chk("wr_status_ok", bus.resp_write_status, 1);
        chk("wr_ready_after_last", bus.req_write_data_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("wr_status_hold", bus.resp_write_status_valid, 1);
        end
        bus.resp_write_status_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_write_status_ready = 1'b0;
        done_cyc = cyc;
        chk("status_drop", bus.resp_write_status_valid, 0);
        chk("idle_after_wr", idle, 1);
        for (int i = 0; i < beats; i++) chk("wr_mem", mem[idx(addr, i)], ref_mem[idx(addr, i)]);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not end, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs_r, hs_w;
        bit ok;
        logic [DW-1:0] d1, d2, v;
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16'h10] = 32'hDEAD_BEEF;
        ref_mem[16'h10] = 32'hDEAD_BEEF;

        bus.req_read_addr = '0;  bus.req_read_addr_valid = 1'b0;  bus.req_read_len = '0;
        bus.req_write_addr = '0; bus.req_write_addr_valid = 1'b0; bus.req_write_len = '0;
        bus.req_write_data = '0; bus.req_write_data_valid = 1'b0;
        bus.resp_read_data_ready = 1'b1; bus.resp_write_status_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_ready", bus.req_read_addr_ready, 0);
        chk("rst_aw_ready", bus.req_write_addr_ready, 0);
        chk("rst_w_ready", bus.req_write_data_ready, 0);
        chk("rst_rvalid", bus.resp_read_data_valid, 0);
        chk("rst_rdata", bus.resp_read_data, 0);
        chk("rst_bvalid", bus.resp_write_status_valid, 0);
        chk("rst_status", bus.resp_write_status, 0);
        chk("rst_dmem_en", dmem_en, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single-beat read with latency check
        rr_mode = 0;
        do_read(32'h10, 32'd1, 1'b1, hs_r);

        // Burst read under a toggling ready pattern
        pat_idx = 0;
        rr_mode = 2;
        do_read(32'h20, 32'd4, 1'b0, hs_r);

        // Burst write with a gap before the second beat and a held status
        rr_mode = 0;
        do_write(32'h40, 32'd3, 1'b1, 1, 2, hs_w);
        chk("wr_plan_0", mem[16'h40], 1);
        chk("wr_plan_1", mem[16'h41], 2);
        chk("wr_plan_2", mem[16'h42], 3);

        // Simultaneous requests: write first, then read sees the new data
        fork
            do_write(32'h100, 32'd2, 1'b0, -1, 0, hs_w);
            do_read(32'h100, 32'd2, 1'b0, hs_r);
        join
        chk("wr_before_rd", hs_r > hs_w, 1);

        // Wrap of the DMem index, len=0, and ignored upper address bits
        rr_mode = 1;
        do_read(32'(DEPTH - 1), 32'd0, 1'b0, hs_r);
        do_read(32'(DEPTH - 1), 32'd2, 1'b0, hs_r);
        do_read(32'hABCD_0000 | 32'(DEPTH - 1), 32'd3, 1'b0, hs_r);
        do_write(32'hFFFF_FFFF, 32'd2, 1'b0, -1, 1, hs_w);
        do_read(32'(DEPTH - 1), 32'd2, 1'b0, hs_r);

        // Reset during the second beat of a 4-beat write
        rr_mode = 0;
        wr_addr_hs(32'h80, 32'd4, ok);
        d1 = DW'($urandom);
        wr_beat(d1, ok);
        if (ok) ref_mem[16'h80] = d1;
        d2 = ~d1;
        bus.req_write_data = d2;
        bus.req_write_data_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_aw_ready", bus.req_write_addr_ready, 0);
        chk("mid_rst_ar_ready", bus.req_read_addr_ready, 0);
        chk("mid_rst_w_ready", bus.req_write_data_ready, 0);
        chk("mid_rst_rvalid", bus.resp_read_data_valid, 0);
        chk("mid_rst_bvalid", bus.resp_write_status_valid, 0);
        chk("mid_rst_dmem_en", dmem_en, 0);
        chk("mid_rst_dmem_we", dmem_we, 0);
        chk("mid_rst_dmem_addr", dmem_addr, 0);
        chk("mid_rst_idle", idle, 1);
        bus.req_write_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_status_after_rst", bus.resp_write_status_valid, 0);
        end
        chk("rst_mem_beat1", mem[16'h80], ref_mem[16'h80]);
        chk("rst_mem_beat2", mem[16'h81], ref_mem[16'h81]);
        rr_mode = 1;
        do_read(32'h80, 32'd4, 1'b0, hs_r);

        // Random bursts
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [31:0] l;
            if ($urandom_range(0, 1) == 1) a = $urandom;
            else a = 32'(DEPTH) - 32'($urandom_range(1, 4));
            l = 32'($urandom_range(0, 6));
            rr_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) do_write(a, l, 1'b0, -2, $urandom_range(0, 3), hs_w);
            else do_read(a, l, 1'b0, hs_r);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/io_dmem_responder.md
# io_dmem_responder

Responder end of the accelerator memory protocol: accepts read and write burst requests from an accelerator (e.g. the 2D convolution engine) and serves them against a single-port, synchronous-read DMem. Sits between the accelerator's read-address, read-data, write-address, write-data and write-status channels and the DMem port. It serializes transactions, one burst at a time. It absorbs read-data backpressure with a 2-entry skid buffer so DMem read latency never drops a beat.

## Interface
- AWIDTH, 32, request address width (word addresses)
- DWIDTH, 32, data width; multiple of 8
- MEM_AWIDTH, 14, DMem index width; DMem index = addr[MEM_AWIDTH-1:0]
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_read_addr  in  AWIDTH  read burst start word address
- req_read_addr_valid  in  1  read request valid
- req_read_addr_ready  out  1  read request accepted
- req_read_len  in  32  read burst length in beats; 0 treated as 1
- resp_read_data  out  DWIDTH  read beat
- resp_read_data_valid  out  1  read beat valid
- resp_read_data_ready  in  1  accelerator accepts beat
- req_write_addr  in  AWIDTH  write burst start word address
- req_write_addr_valid  in  1  write request valid
- req_write_addr_ready  out  1  write request accepted
- req_write_len  in  32  write burst length in beats; 0 treated as 1
- req_write_data  in  DWIDTH  write beat
- req_write_data_valid  in  1  write beat valid
- req_write_data_ready  out  1  write beat accepted
- resp_write_status  out  1  1 = OK (always 1 when valid)
- resp_write_status_valid  out  1  status valid
- resp_write_status_ready  in  1  status accepted
- dmem_addr  out  MEM_AWIDTH  DMem index
- dmem_en  out  1  DMem access enable
- dmem_we  out  DWIDTH/8  byte write enables (all 1s on write, 0 on read)
- dmem_din  out  DWIDTH  DMem write data
- dmem_dout  in  DWIDTH  DMem read data, valid the cycle after dmem_en with dmem_we = 0
- idle  out  1  FSM in IDLE, skid buffer empty, no read in flight

## Operation
- States: IDLE, RD, WR, WRESP.
- IDLE: req_read_addr_ready and req_write_addr_ready are 1 only in IDLE. Write has fixed priority. If req_write_addr_valid, only the write ready is asserted. The handshake latches the address and length; the FSM moves to WR. Otherwise a read handshake latches and moves to RD.
- A handshake is valid & ready in the same cycle. Payload is sampled on that edge.
- RD: issue DMem reads at consecutive addresses, one per cycle. Issue only while (buffer occupancy + reads in flight) < 2 and beats remain to issue.
  - Returned dmem_dout enters the 2-entry FIFO.
  - resp_read_data_valid = FIFO non-empty; resp_read_data = FIFO head.
  - Return to IDLE once every beat is issued and the FIFO has drained (last beat handshaken).
- WR: req_write_data_ready = 1. Each beat handshake drives dmem_en = 1, dmem_we = all 1s, dmem_addr = current address, dmem_din = data, in the same cycle (combinational). The address then increments.
  - After the final beat, move to WRESP.
- WRESP: resp_write_status_valid = 1, resp_write_status = 1, until resp_write_status_ready; then IDLE.
- Address arithmetic: a 32-bit beat counter; the address increments by 1 per beat. The DMem index wraps modulo 2^MEM_AWIDTH; upper address bits are ignored.
- Beats outside the current burst are never accepted: req_write_data_ready = 0 outside WR.

## Timing
- Reset values: all ready and valid outputs 0, dmem_en 0, dmem_we 0, dmem_addr 0, resp_read_data 0, resp_write_status 0, idle 1. FSM in IDLE, FIFO empty.
- Reset asserted mid-burst: all state is cleared at once. The partial burst is abandoned with no further beats or status. DMem contents already written are kept.
- Read latency: address handshake at edge N → first dmem_en at cycle N+1 → resp_read_data_valid at cycle N+2.
- With resp_read_data_ready held 1, throughput is 1 beat/cycle.
- With ready low, at most 2 beats are buffered; data and valid hold stable until accepted.
- Write: 1 beat/cycle. Status is valid the cycle after the last data handshake.
- Minimum turnaround: 1 cycle in IDLE between bursts.
- Simultaneous read and write requests in IDLE: write is served first, and the read waits with its ready low.

## Test plan
- Single-beat read, len=1, addr 0x10, DMem[0x10]=0xDEADBEEF, ready held 1 -> one beat 0xDEADBEEF two cycles after the handshake; idle is 1 the cycle after.
- Burst read, len=4, addr 0x20, with ready toggling 1,0,0,1,1,0,1 -> beats DMem[0x20..0x23] in order, none dropped or duplicated; data stable while stalled; at most 2 reads outstanding.
- Burst write, len=3, addr 0x40, data 1,2,3 with a one-cycle data_valid gap -> DMem[0x40..0x42]=1,2,3; status valid (=1) the cycle after the third beat, held until ready.
- Read and write requests valid in the same IDLE cycle -> write served first; the read is then served and returns the just-written data.
- len=0 read at addr 2^MEM_AWIDTH-1 and a 2-beat read at the same addr -> len=0 returns exactly 1 beat; the 2-beat burst returns DMem[2^MEM_AWIDTH-1] then DMem[0].
- rst driven low during the second beat of a 4-beat write -> all outputs reach reset values immediately; DMem holds only beat 1; a new read after release completes normally.
